// File: rtl/apuf_pkg.sv
// Shared types and defaults for the arbiter PUF primitive.
package apuf_pkg;

    localparam int unsigned N_STAGES_DEF = 64;
    localparam logic        TIE_RESP_DEF = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } apufState_t;

    // Arbiter decision: top-only wins 1, bottom-only 0, both -> tie value, neither -> 0.
    function automatic logic arbDecide(input logic t, input logic b, input logic tie);
        return (t & ~b) | (t & b & tie);
    endfunction

endpackage

// File: rtl/apuf_switch_stage.sv
// One 2x2 crossbar stage of the arbiter chain: sel=0 passes straight, sel=1 crosses.
module apuf_switch_stage (
    input  logic tIn,
    input  logic bIn,
    input  logic sel,
    output logic tOut,
    output logic bOut
);

    assign tOut = sel ? bIn : tIn;
    assign bOut = sel ? tIn : bIn;

endmodule

// File: rtl/apuf_classic.sv
// Classic arbiter PUF: synchronised trigger launches an edge into two
// challenge-configured rails, an arbiter samples the rail ends after a settle delay.
module apuf_classic
    import apuf_pkg::*;
#(
    parameter int unsigned N_STAGES      = N_STAGES_DEF,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic        TIE_RESP      = TIE_RESP_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tigSignal,
    input  logic                vcc,
    input  logic [N_STAGES-1:0] c,
    output logic                respReady,
    output logic                respBit,
    output logic                pathT,
    output logic                pathB,
    output logic                tigOut
);

    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

    apufState_t          state;
    logic                tigSync1;
    logic                tigSync2;
    logic                tigPrev;
    logic                tigRise;
    logic [CNT_W-1:0]    settleCnt;
    logic [N_STAGES-1:0] cQ;
    logic [N_STAGES:0]   railT;
    logic [N_STAGES:0]   railB;

    assign tigRise = tigSync2 & ~tigPrev;

    // Both rails are driven from the same gated launch edge.
    assign railT[0] = tigOut & vcc;
    assign railB[0] = tigOut & vcc;

    for (genvar i = 0; i < N_STAGES; i++) begin : gStage
        (* keep = "true", dont_touch = "true" *)
        apuf_switch_stage uStage (
            .tIn  (railT[i]),
            .bIn  (railB[i]),
            .sel  (cQ[i]),
            .tOut (railT[i+1]),
            .bOut (railB[i+1])
        );
    end

    assign pathT = railT[N_STAGES];
    assign pathB = railB[N_STAGES];

    // Synchroniser, edge detector, launch/decision FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tigSync1  <= 1'b0;
            tigSync2  <= 1'b0;
            tigPrev   <= 1'b0;
            settleCnt <= '0;
            cQ        <= '0;
            tigOut    <= 1'b0;
            respReady <= 1'b0;
            respBit   <= 1'b0;
        end else begin
            tigSync1 <= tigSignal;
            tigSync2 <= tigSync1;
            tigPrev  <= tigSync2;
            if (!vcc) begin
                state     <= IDLE;
                settleCnt <= '0;
                tigOut    <= 1'b0;
                respReady <= 1'b0;
                respBit   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (tigRise) begin
                            state     <= RUN;
                            cQ        <= c;
                            tigOut    <= 1'b1;
                            settleCnt <= CNT_W'(SETTLE_CYCLES);
                        end
                    end
                    RUN: begin
                        // Decide on the edge where the counter would reach zero.
                        if (settleCnt <= CNT_W'(1)) begin
                            settleCnt <= '0;
                            respBit   <= arbDecide(pathT, pathB, TIE_RESP);
                            respReady <= 1'b1;
                            state     <= DONE;
                        end else begin
                            settleCnt <= settleCnt - CNT_W'(1);
                        end
                    end
                    DONE: begin
                        if (!tigSync2) begin
                            tigOut    <= 1'b0;
                            respReady <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_apuf_classic.sv
// Self-checking bench for apuf_classic: cycle vector table plus hand-written corner sequences.
module tb_apuf_classic;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tigSignal;
    logic        vcc;
    logic [63:0] c;
    logic        respReady;
    logic        respBit;
    logic        pathT;
    logic        pathB;
    logic        tigOut;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        vcc;
        logic        tig;
        logic [63:0] c;
        logic [4:0]  expOut;   // {tigOut, pathT, pathB, respReady, respBit}
        string       name;
    } vec_t;

    vec_t vecs[$];

    apuf_classic dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tigSignal (tigSignal),
        .vcc       (vcc),
        .c         (c),
        .respReady (respReady),
        .respBit   (respBit),
        .pathT     (pathT),
        .pathB     (pathB),
        .tigOut    (tigOut)
    );

    always #50 clk = ~clk;

    function automatic logic [4:0] outs();
        return {tigOut, pathT, pathB, respReady, respBit};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    task automatic addVec(input logic v, input logic t, input logic [63:0] cv,
                          input logic [4:0] e, input string n);
        vec_t x;
        x.vcc = v; x.tig = t; x.c = cv; x.expOut = e; x.name = n;
        vecs.push_back(x);
    endtask

    localparam logic [63:0] C_ALT  = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] C_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        rst_n = 1'b0; tigSignal = 1'b1; vcc = 1'b1; c = '0;

        // Reset with trigger and power high: everything zero.
        #10;
        chk("reset_outs", 64'(outs()), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #10;
        @(posedge clk); #10;
        chk("rst_rel_edge2_tigOut", 64'(tigOut), 64'h0);
        @(posedge clk); #10;
        chk("rst_rel_edge3_tigOut", 64'(tigOut), 64'h1);

        // Fresh reset for the table run.
        @(negedge clk);
        rst_n = 1'b0; tigSignal = 1'b0; vcc = 1'b0; c = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // Nominal launch, tie response, hold, re-arm.
        addVec(1, 0, '0, 5'b00000, "nom_idle");
        addVec(1, 1, '0, 5'b00000, "nom_e1");
        addVec(1, 1, '0, 5'b00000, "nom_e2");
        addVec(1, 1, '0, 5'b11100, "nom_e3_launch");
        addVec(1, 1, '0, 5'b11100, "nom_e4_run");
        addVec(1, 1, '0, 5'b11111, "nom_e5_decide");
        addVec(1, 1, '0, 5'b11111, "nom_done_hold");
        addVec(1, 0, '0, 5'b11111, "fall_e1");
        addVec(1, 0, '0, 5'b11111, "fall_e2");
        addVec(1, 0, '0, 5'b00001, "fall_e3_clear");
        // Second launch with alternating challenge, then change during RUN.
        addVec(1, 1, C_ALT,  5'b00001, "re_e1");
        addVec(1, 1, C_ALT,  5'b00001, "re_e2");
        addVec(1, 1, C_ALT,  5'b11101, "re_e3_launch");
        addVec(1, 1, C_ONES, 5'b11101, "re_e4_cchange");
        addVec(1, 1, C_ONES, 5'b11111, "re_e5_decide");
        // Power drop in DONE, then trigger toggling while unpowered.
        addVec(0, 1, C_ONES, 5'b00000, "vcc_off_done");
        addVec(0, 0, C_ONES, 5'b00000, "vcc_off_t0");
        addVec(0, 1, C_ONES, 5'b00000, "vcc_off_t1");
        addVec(0, 1, C_ONES, 5'b00000, "vcc_off_t1b");
        addVec(0, 0, C_ONES, 5'b00000, "vcc_off_t0b");
        addVec(1, 0, '0, 5'b00000, "pwr_idle0");
        addVec(1, 0, '0, 5'b00000, "pwr_idle1");
        addVec(1, 0, '0, 5'b00000, "pwr_idle2");
        // Abort during RUN: no response, respBit cleared, no relaunch while trigger stays high.
        addVec(1, 1, C_ALT, 5'b00000, "ab_e1");
        addVec(1, 1, C_ALT, 5'b00000, "ab_e2");
        addVec(1, 1, C_ALT, 5'b11100, "ab_e3_launch");
        addVec(0, 1, C_ALT, 5'b00000, "ab_vcc_drop");
        addVec(1, 1, C_ALT, 5'b00000, "ab_no_relaunch0");
        addVec(1, 1, C_ALT, 5'b00000, "ab_no_relaunch1");
        addVec(1, 1, C_ALT, 5'b00000, "ab_no_relaunch2");

        foreach (vecs[i]) begin
            vcc = vecs[i].vcc; tigSignal = vecs[i].tig; c = vecs[i].c;
            @(posedge clk); #10;
            chk(vecs[i].name, 64'(outs()), 64'(vecs[i].expOut));
            @(negedge clk);
        end

        // Re-arm and measure launch-to-response latency with a bounded wait.
        tigSignal = 1'b0;
        repeat (3) @(negedge clk);
        tigSignal = 1'b1;
        begin
            int n = 0;
            while (!respReady && n < 10) begin
                @(posedge clk); #10;
                n++;
            end
            chk("resp_latency_edges", 64'(n), 64'd5);
        end
        @(negedge clk);

        // Rails follow vcc combinationally while the launch register still holds.
        vcc = 1'b0;
        #1;
        chk("vcc_drop_rails", 64'({tigOut, pathT, pathB}), 64'b100);
        vcc = 1'b1;
        #1;
        chk("vcc_restore_rails", 64'({pathT, pathB}), 64'b11);

        // Asynchronous reset mid-DONE clears outputs without a clock edge.
        rst_n = 1'b0;
        #1;
        chk("rst_mid_done", 64'(outs()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apuf_classic.md
# apuf_classic

Classic 64-stage arbiter PUF (APUF) primitive used as the building block of the interpose-PUF datapath. A clock-synchronised trigger launches one edge into two symmetric switch-stage chains configured by the challenge. An arbiter decision yields a one-bit response flagged by `respReady`. Raw chain ends and the launch edge are exported for on-chip probing and external arbiters.

## Interface
- `N_STAGES`, 64: number of switch stages; challenge width.
- `SETTLE_CYCLES`, 2: clk cycles from launch to arbiter decision (≥1).
- `TIE_RESP`, 1'b1: response when both rails are high at the decision edge.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tigSignal`  in  1  asynchronous trigger; rising edge launches, falling edge re-arms.
- `vcc`  in  1  chain enable ("power"); 0 forces chain, launch and FSM idle.
- `c`  in  N_STAGES  challenge; latched at launch.
- `respReady`  out  1  response valid.
- `respBit`  out  1  arbiter response.
- `pathT`  out  1  top-rail output of last stage.
- `pathB`  out  1  bottom-rail output of last stage.
- `tigOut`  out  1  registered launch edge driving both chain inputs.

## Operation
- `tigSignal` passes a 2-flop synchroniser, then a rising-edge detector.
- FSM states: IDLE, RUN, DONE.
- IDLE: on detected rising edge with `vcc`=1 → RUN; latch `c` into `c_q`; set launch register (`tigOut`=1); load settle counter with SETTLE_CYCLES.
- Chain: rail inputs T0=B0=launch & vcc. Stage i: `c_q[i]`=0 passes straight (T'=T, B'=B); 1 crosses (T'=B, B'=T). `pathT`/`pathB` are the stage N_STAGES−1 outputs, purely combinational.
- RUN: counter decrements each edge. When it reaches 0, capture the decision and go to DONE:
  - `respBit`=1 if pathT&~pathB.
  - `respBit`=0 if ~pathT&pathB.
  - `respBit`=TIE_RESP if both are high.
  - `respBit`=0 if neither is high.
  - `respReady`=1.
- DONE: hold `respBit`, `respReady`, `tigOut` until the synchronised `tigSignal` is low. Then clear `tigOut` and `respReady` and return to IDLE. `respBit` holds until the next decision.
- `c` changes after launch have no effect until the next launch.
- A new rising edge during RUN or DONE is ignored; re-arm requires `tigSignal` low.
- `vcc`=0 in any state, synchronous: next edge → IDLE, `tigOut`=0, `respReady`=0, `respBit`=0. Rails drop combinationally at once.
- `rst_n` low, any state: immediately clears FSM to IDLE, all registers to 0, all outputs to 0.

## Timing
- Counting the first rising edge that sees `tigSignal` high as edge 1:
  - `tigOut`, `pathT`, `pathB` rise after edge 3.
  - Decision is taken and `respReady` rises at edge 3+SETTLE_CYCLES (edge 5 by default).
- `tigSignal` fall: `tigOut` and `respReady` clear at the 3rd edge seeing it low.
- Release of `rst_n` is synchronised; the first launch is possible 3 edges after release.
- Chain stages carry keep/dont_touch attributes so synthesis preserves the symmetric rail structure. RTL delays are zero, so simulated rails always match; the race is resolved by the tie rule.

## Structure
- Shared package `apuf_pkg`: default N_STAGES, state enum (IDLE/RUN/DONE), TIE_RESP default.
- One sub-module `apuf_switch_stage`: 2×2 crossbar (inputs T, B, sel; outputs T', B'), generate-instantiated N_STAGES times.
- Top holds the synchroniser, edge detector, FSM, counter and decision register.

## Test plan
- Reset: `rst_n`=0 with `tigSignal`=1, `vcc`=1 → all five outputs 0. Release; within 3 edges `tigOut`=1.
- Nominal (100 ns clk; `vcc`=1 at 100 ns; `c`=0; `tigSignal`↑ at 200 ns):
  - `tigOut`=`pathT`=`pathB`=1 after the 450 ns edge.
  - `respReady`=1 and `respBit`=1 (tie) after the 650 ns edge.
- `vcc`=0 held, `tigSignal` toggled → `tigOut`, `respReady` stay 0; paths stay 0.
- Challenge latch: launch with `c`=64'hAAAA_AAAA_AAAA_AAAA, then change `c` to all-ones during RUN → `respReady` timing unchanged, rails unchanged.
- Re-arm: `tigSignal`↓ → `respReady`/`tigOut` cleared 3 edges later and `respBit` held. A second ↑ produces a new `respReady` pulse.
- Abort: drop `vcc` during RUN → next edge IDLE, `respBit`=0, no `respReady`. Assert `rst_n` mid-DONE → outputs 0 immediately.
